// File: rtl/game_score_unit.sv
// game_score_unit: apple score, win/die codes and score-paced move tick for the snake game.
module game_score_unit #(
    parameter int unsigned WIN_SCORE = 13,
    parameter int unsigned DIE_CODE  = 15,
    parameter int unsigned BASE_DIV  = 25_000_000,
    parameter int unsigned STEP_DIV  = 1_500_000,
    parameter int unsigned MIN_DIV   = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       middle_set,
    input  logic [1:0] mode,
    input  logic       eat_pulse,
    input  logic       collide_pulse,
    output logic [3:0] score,
    output logic [4:0] length,
    output logic       move_tick,
    output logic       playing
);
    typedef enum logic [1:0] {IDLE, PLAY, DEAD, WON} state_t;
    state_t      state, state_n;
    logic [3:0]  apples, apples_n, score_n;
    logic [2:0]  sync;
    logic        start_edge;
    logic [31:0] step_total, period, tick_cnt;
    assign start_edge = sync[1] & ~sync[2];
    assign step_total = 32'(apples) * STEP_DIV;
    // guarded subtraction so a large apple count can never wrap the period
    assign period     = (step_total >= BASE_DIV || BASE_DIV - step_total < MIN_DIV) ? MIN_DIV : BASE_DIV - step_total;
    assign move_tick  = (state == PLAY) && (tick_cnt >= period - 32'd1);
    assign playing    = (state == PLAY);
    always_comb begin
        state_n  = state;
        apples_n = apples;
        score_n  = score;
        case (state)
            IDLE: begin
                apples_n = '0;
                score_n  = '0;
                if (mode == 2'b01) state_n = PLAY;
            end
            PLAY: begin
                if (collide_pulse) begin
                    state_n = DEAD;
                    score_n = 4'(DIE_CODE);
                end else if (eat_pulse) begin
                    apples_n = apples + 4'd1;
                    score_n  = apples_n;
                    if (apples_n == 4'(WIN_SCORE)) state_n = WON;
                end else if (mode == 2'b00) begin
                    state_n  = IDLE;
                    apples_n = '0;
                    score_n  = '0;
                end
            end
            DEAD, WON: begin
                if (start_edge) begin
                    state_n  = IDLE;
                    apples_n = '0;
                    score_n  = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            apples   <= '0;
            score    <= '0;
            length   <= 5'd3;
            tick_cnt <= '0;
            sync     <= '0;
        end else begin
            state    <= state_n;
            apples   <= apples_n;
            score    <= score_n;
            length   <= 5'd3 + {1'b0, apples_n};
            tick_cnt <= (state == PLAY && state_n == PLAY && !move_tick) ? tick_cnt + 32'd1 : '0;
            sync     <= {sync[1:0], middle_set};
        end
    end
endmodule
